led_shift_driver: RTL and testbench
===================================

// Module: led_shift_driver
// PURPOSE
//   Serial transmitter for the board's LED output chain (74HC595-style SIPO shift registers).
//   Accepts a parallel WIDTH-bit word from the CPU side and shifts it out MSB first on sr_data_out/sr_clk_out.
//   After the last bit it pulses latch_out so all LEDs update together.
//   It is the output-side counterpart of the sensor shift-register reader and shares the same slow serial clock scheme.
// PARAMETERS
//   WIDTH    32   number of bits shifted per frame (>=1)
//   CLK_DIV  100  clk cycles per half-period of sr_clk_out; also the latch pulse width in clk cycles (>=1)
// PORTS
//   clk          in   1      system clock; all logic on posedge
//   reset_n      in   1      asynchronous, active-low reset
//   data_in      in   WIDTH  word to transmit; sampled only on an accepted start
//   start        in   1      request a frame; accepted only when busy==0
//   busy         out  1      frame in progress (registered)
//   done         out  1      one-clk pulse marking the final cycle of a frame
//   sr_clk_out   out  1      shift clock to the chain; the chain samples on its rising edge
//   sr_data_out  out  1      serial data, stable for the whole high and low phase of each bit
//   latch_out    out  1      storage-register clock (RCLK), active-high pulse
// BEHAVIOUR
//   - Reset (async, reset_n=0): state=IDLE and all outputs 0 (busy, done, sr_clk_out, sr_data_out, latch_out).
//     Shadow register, divider and bit counters clear to 0.
//   - Every output is a register; no combinational path from any input to any output.
//   - States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
//   - IDLE:
//     - On an edge with start=1: shadow<=data_in, bit_idx<=WIDTH-1, sr_data_out<=data_in[WIDTH-1],
//       sr_clk_out<=0, busy<=1, div<=0, state->SHIFT_LO.
//     - start=0: all outputs hold 0.
//   - SHIFT_LO: sr_clk_out=0 for exactly CLK_DIV cycles, then sr_clk_out<=1 and state->SHIFT_HI.
//   - SHIFT_HI: sr_clk_out=1 for exactly CLK_DIV cycles, then sr_clk_out<=0.
//     - If bit_idx>0: bit_idx<=bit_idx-1, sr_data_out<=shadow[bit_idx-1], state->SHIFT_LO.
//     - If bit_idx==0: sr_data_out<=0, latch_out<=1, state->LATCH.
//   - sr_data_out changes only on the same edge as the falling edge of sr_clk_out, giving CLK_DIV cycles of setup and hold.
//   - LATCH: latch_out=1 for exactly CLK_DIV cycles with sr_clk_out=0, then latch_out<=0, done<=1, state->DONE.
//   - DONE: lasts 1 cycle with busy=1, done=1; then busy<=0, done<=0, state->IDLE.
//   - Frame timing: busy is high for (2*WIDTH+1)*CLK_DIV+1 cycles; exactly WIDTH rising edges on sr_clk_out;
//     exactly one latch_out pulse per frame, always after the last rising edge.
//   - start while busy=1 (including during DONE): ignored, not queued; shadow is unaffected.
//     start held high continuously: the next frame is accepted on the first IDLE cycle, so frames run back to back
//     with 1 idle cycle between them.
//   - data_in changes after acceptance: no effect on the current frame.
//   - Reset asserted mid-frame: all outputs drop to 0 at once and no latch pulse is issued, so the LEDs keep the
//     last latched frame. The partially shifted chain contents are overwritten by the next full frame.
//   - Counter widths: divider $clog2(CLK_DIV+1), bit_idx $clog2(WIDTH+1). No wrap-around in normal operation,
//     because each counter is reset on every state transition.
// TESTING
//   1. Reset check: hold reset_n=0, toggle start and data_in -> all outputs stay 0; release reset -> still IDLE, busy=0.
//   2. WIDTH=8, CLK_DIV=2, send data_in=8'hA5 -> bits 1,0,1,0,0,1,0,1 are sampled on the 8 sr_clk_out rises;
//      latch_out is high for 2 clks; busy is high for 35 clks; done pulses once, on busy's last cycle.
//   3. Defaults (WIDTH=32, CLK_DIV=100), send 32'h8000_0001 -> first and last bits sampled as 1 and the rest 0;
//      each phase lasts 100 clks; busy is high for 6501 clks.
//   4. Issue start at mid-frame and again during DONE, with a different data_in -> ignored; exactly one frame,
//      carrying the original data.
//   5. Hold start=1 with data_in=8'hFF then 8'h00 (WIDTH=8, CLK_DIV=2) -> two frames with 1 idle clk between them;
//      two latch pulses; the second frame shifts all zeros.
//   6. Pull reset_n low during bit 3 of a frame -> outputs go to 0 asynchronously, with no latch pulse.
//      A new start after release -> a clean, full-length frame.

Source files
------------

// File: rtl/led_shift_driver.sv
// Serial transmitter for a 74HC595-style LED chain: shifts a parallel word out MSB first,
// then pulses the storage-register clock so every LED updates together.
module led_shift_driver #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sr_clk_out,
  output logic             sr_data_out,
  output logic             latch_out
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] IDX_MSB  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             sr_clk_q;
  logic             sr_data_q;
  logic             latch_q;
  logic             div_last;

  // The shadow shifts left once per bit, so its MSB is always the next bit to send.
  assign shadow_d = shadow_q << 1;
  assign div_last = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sr_clk_q  <= 1'b0;
      sr_data_q <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_q  <= data_in;
            bit_idx_q <= IDX_MSB;
            sr_data_q <= data_in[WIDTH-1];
            sr_clk_q  <= 1'b0;
            busy_q    <= 1'b1;
            div_q     <= '0;
            state_q   <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (div_last) begin
            div_q    <= '0;
            sr_clk_q <= 1'b1;
            state_q  <= S_SHIFT_HI;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (div_last) begin
            div_q    <= '0;
            sr_clk_q <= 1'b0;
            // Data only moves on the falling edge of sr_clk, giving a full phase of setup and hold.
            if (bit_idx_q != '0) begin
              bit_idx_q <= bit_idx_q - 1'b1;
              shadow_q  <= shadow_d;
              sr_data_q <= shadow_d[WIDTH-1];
              state_q   <= S_SHIFT_LO;
            end else begin
              sr_data_q <= 1'b0;
              latch_q   <= 1'b1;
              state_q   <= S_LATCH;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_LATCH: begin
          if (div_last) begin
            div_q   <= '0;
            latch_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sr_clk_out  = sr_clk_q;
  assign sr_data_out = sr_data_q;
  assign latch_out   = latch_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: a small-config instance for most scenarios and a default-config
// instance for full-size timing, both checked every cycle against a frame-timeline model.
module tb_led_shift_driver;

  localparam int WA = 8;
  localparam int DA = 2;
  localparam int LEN_A = (2 * WA + 1) * DA + 1;
  localparam int WB = 32;
  localparam int DB = 100;
  localparam int LEN_B = (2 * WB + 1) * DB + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [WA-1:0] data_a = '0;
  logic          start_a = 1'b0;
  logic [WB-1:0] data_b = '0;
  logic          start_b = 1'b0;
  logic busy_a, done_a, srclk_a, srdata_a, latch_a;
  logic busy_b, done_b, srclk_b, srdata_b, latch_b;

  int vectors = 0;
  int miscompares = 0;

  led_shift_driver #(.WIDTH(WA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_a), .start(start_a),
    .busy(busy_a), .done(done_a), .sr_clk_out(srclk_a), .sr_data_out(srdata_a),
    .latch_out(latch_a)
  );

  led_shift_driver dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_b), .start(start_b),
    .busy(busy_b), .done(done_b), .sr_clk_out(srclk_b), .sr_data_out(srdata_b),
    .latch_out(latch_b)
  );

  always #5 clk = ~clk;

  // Frame-timeline model: k counts cycles since the accepting edge.
  bit          ma_act = 1'b0;
  int          ma_k = 0;
  logic [31:0] ma_data = '0;
  bit          mb_act = 1'b0;
  int          mb_k = 0;
  logic [31:0] mb_data = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma_act <= 1'b0;
      ma_k   <= 0;
    end else if (ma_act) begin
      if (ma_k == LEN_A - 1) ma_act <= 1'b0;
      else ma_k <= ma_k + 1;
    end else if (start_a) begin
      ma_act  <= 1'b1;
      ma_k    <= 0;
      ma_data <= {24'b0, data_a};
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb_act <= 1'b0;
      mb_k   <= 0;
    end else if (mb_act) begin
      if (mb_k == LEN_B - 1) mb_act <= 1'b0;
      else mb_k <= mb_k + 1;
    end else if (start_b) begin
      mb_act  <= 1'b1;
      mb_k    <= 0;
      mb_data <= data_b;
    end
  end

  // Returns {busy, done, sr_clk, sr_data, latch} for cycle k of a frame.
  function automatic logic [4:0] expect_outs(input bit act, input int k, input int w,
                                             input int d, input logic [31:0] data);
    logic [31:0] sh;
    logic b, dn, sc, sd, la;
    b = 1'b0; dn = 1'b0; sc = 1'b0; sd = 1'b0; la = 1'b0;
    if (act) begin
      b  = 1'b1;
      dn = (k == (2 * w + 1) * d);
      if (k < 2 * w * d) begin
        sc = ((k / d) % 2) == 1;
        sh = data >> (w - 1 - k / (2 * d));
        sd = sh[0];
      end else if (k < (2 * w + 1) * d) begin
        la = 1'b1;
      end
    end
    return {b, dn, sc, sd, la};
  endfunction

  // Observation counters on the DUT pins.
  int          rises_a = 0, rises_b = 0, lpulse_a = 0, lpulse_b = 0;
  int          busyc_a = 0, busyc_b = 0, latchc_a = 0, latchc_b = 0, donec_a = 0, donec_b = 0;
  logic [31:0] cap_a = '0, cap_b = '0;

  always @(posedge srclk_a) begin
    rises_a <= rises_a + 1;
    cap_a   <= {cap_a[30:0], srdata_a};
  end
  always @(posedge srclk_b) begin
    rises_b <= rises_b + 1;
    cap_b   <= {cap_b[30:0], srdata_b};
  end
  always @(posedge latch_a) lpulse_a <= lpulse_a + 1;
  always @(posedge latch_b) lpulse_b <= lpulse_b + 1;
  always @(negedge clk) begin
    if (busy_a)  busyc_a  <= busyc_a + 1;
    if (busy_b)  busyc_b  <= busyc_b + 1;
    if (latch_a) latchc_a <= latchc_a + 1;
    if (latch_b) latchc_b <= latchc_b + 1;
    if (done_a)  donec_a  <= donec_a + 1;
    if (done_b)  donec_b  <= donec_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("cycle_a", {27'b0, busy_a, done_a, srclk_a, srdata_a, latch_a},
            {27'b0, expect_outs(ma_act, ma_k, WA, DA, ma_data)});
      check("cycle_b", {27'b0, busy_b, done_b, srclk_b, srdata_b, latch_b},
            {27'b0, expect_outs(mb_act, mb_k, WB, DB, mb_data)});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit on_b, input int budget);
    int n = 0;
    while (((on_b ? done_b : done_a) !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("timeout_done", 32'(n), 32'(budget - 1));
  endtask

  task automatic wait_rises_a(input int target, input int budget);
    int n = 0;
    while (rises_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("timeout_rises", 32'(rises_a), 32'(target));
  endtask

  int r0, l0, b0, lc0, d0;

  task automatic snap_a();
    r0 = rises_a; l0 = lpulse_a; b0 = busyc_a; lc0 = latchc_a; d0 = donec_a;
  endtask

  task automatic send_a(input logic [WA-1:0] d);
    data_a  = d;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // 1: reset held, inputs toggling, outputs must stay 0.
    #2 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      start_a = i[0];
      start_b = i[0];
      data_a  = 8'($urandom);
      data_b  = $urandom;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    reset_n = 1'b1;
    tick(2);
    check("post_reset_outs_a", {27'b0, busy_a, done_a, srclk_a, srdata_a, latch_a}, 32'h0);
    check("post_reset_outs_b", {27'b0, busy_b, done_b, srclk_b, srdata_b, latch_b}, 32'h0);
    $display("scenario reset: vectors=%0d", vectors);

    // 2: single 8-bit frame of A5.
    snap_a();
    send_a(8'hA5);
    wait_done(1'b0, 100);
    tick(3);
    check("a5_bits", {24'b0, cap_a[7:0]}, 32'hA5);
    check("a5_rises", 32'(rises_a - r0), 32'd8);
    check("a5_latch_cycles", 32'(latchc_a - lc0), 32'd2);
    check("a5_busy_cycles", 32'(busyc_a - b0), 32'd35);
    check("a5_done_pulses", 32'(donec_a - d0), 32'd1);
    check("a5_latch_pulses", 32'(lpulse_a - l0), 32'd1);
    $display("scenario frame A5: vectors=%0d", vectors);

    // 3: default-size frame.
    r0 = rises_b; l0 = lpulse_b; b0 = busyc_b; lc0 = latchc_b;
    data_b  = 32'h8000_0001;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done(1'b1, 7000);
    tick(3);
    check("wide_bits", cap_b, 32'h8000_0001);
    check("wide_rises", 32'(rises_b - r0), 32'd32);
    check("wide_busy_cycles", 32'(busyc_b - b0), 32'd6501);
    check("wide_latch_cycles", 32'(latchc_b - lc0), 32'd100);
    check("wide_latch_pulses", 32'(lpulse_b - l0), 32'd1);
    $display("scenario wide frame: vectors=%0d", vectors);

    // 4: starts mid-frame and during DONE are ignored.
    snap_a();
    send_a(8'hC3);
    wait_rises_a(r0 + 4, 100);
    data_a  = 8'h3C;
    start_a = 1'b1;
    tick(2);
    start_a = 1'b0;
    wait_done(1'b0, 100);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    tick(4);
    check("ignore_bits", {24'b0, cap_a[7:0]}, 32'hC3);
    check("ignore_latch_pulses", 32'(lpulse_a - l0), 32'd1);
    check("ignore_busy_cycles", 32'(busyc_a - b0), 32'd35);
    check("ignore_idle_after", {31'b0, busy_a}, 32'd0);
    $display("scenario ignored starts: vectors=%0d", vectors);

    // 5: start held high, back-to-back frames FF then 00.
    snap_a();
    data_a  = 8'hFF;
    start_a = 1'b1;
    tick(1);
    data_a  = 8'h00;
    wait_done(1'b0, 100);
    tick(1);
    check("b2b_idle_gap", {31'b0, busy_a}, 32'd0);
    tick(1);
    check("b2b_second_busy", {31'b0, busy_a}, 32'd1);
    start_a = 1'b0;
    wait_done(1'b0, 100);
    tick(3);
    check("b2b_bits", {16'b0, cap_a[15:0]}, 32'hFF00);
    check("b2b_latch_pulses", 32'(lpulse_a - l0), 32'd2);
    check("b2b_busy_cycles", 32'(busyc_a - b0), 32'd70);
    check("b2b_rises", 32'(rises_a - r0), 32'd16);
    $display("scenario back-to-back: vectors=%0d", vectors);

    // 6: reset during bit 3, then a clean frame.
    snap_a();
    send_a(8'hA5);
    wait_rises_a(r0 + 3, 100);
    reset_n = 1'b0;
    #1;
    check("abort_outs_async", {27'b0, busy_a, done_a, srclk_a, srdata_a, latch_a}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("abort_no_latch", 32'(lpulse_a - l0), 32'd0);
    snap_a();
    send_a(8'h3C);
    wait_done(1'b0, 100);
    tick(3);
    check("recover_bits", {24'b0, cap_a[7:0]}, 32'h3C);
    check("recover_rises", 32'(rises_a - r0), 32'd8);
    check("recover_busy_cycles", 32'(busyc_a - b0), 32'd35);
    check("recover_latch_pulses", 32'(lpulse_a - l0), 32'd1);
    $display("scenario reset abort: vectors=%0d", vectors);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
